// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: deserialises frames, tracks E0/F0/E1 prefixes, emits toggle-strobed key events.
// Optional error counter output enabled by defining PS2_RX_ERRCNT_EN.
module ps2_key_receiver #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        err
`ifdef PS2_RX_ERRCNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clkMeta_q, clkSync_q, dataMeta_q, dataSync_q;
  logic          clkFilt_q, clkFiltPrev_q;
  logic [FW-1:0] filtCnt_q;
  logic          fall;

  state_t        state_q, state_d;
  logic [2:0]    bitCnt_q, bitCnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] toCnt_q, toCnt_d;
  logic          ext_q, ext_d, rel_q, rel_d;
  logic [2:0]    skip_q, skip_d;
  logic [10:0]   key_q, key_d;
  logic          err_q, err_d;
  logic          deliver, timeout;

  // Idle PS/2 lines are high, so the synchronisers and filter reset to 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      clkMeta_q     <= 1'b1;
      clkSync_q     <= 1'b1;
      dataMeta_q    <= 1'b1;
      dataSync_q    <= 1'b1;
      clkFilt_q     <= 1'b1;
      clkFiltPrev_q <= 1'b1;
      filtCnt_q     <= '0;
    end else begin
      clkMeta_q     <= ps2_clk;
      clkSync_q     <= clkMeta_q;
      dataMeta_q    <= ps2_data;
      dataSync_q    <= dataMeta_q;
      clkFiltPrev_q <= clkFilt_q;
      if (clkSync_q != clkFilt_q) begin
        if (filtCnt_q == FW'(FILTER_LEN - 1)) begin
          clkFilt_q <= clkSync_q;
          filtCnt_q <= '0;
        end else begin
          filtCnt_q <= filtCnt_q + FW'(1);
        end
      end else begin
        filtCnt_q <= '0;
      end
    end
  end

  assign fall    = clkFiltPrev_q & ~clkFilt_q;
  assign timeout = (state_q != IDLE) && (toCnt_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      bitCnt_q <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      toCnt_q  <= '0;
      ext_q    <= 1'b0;
      rel_q    <= 1'b0;
      skip_q   <= '0;
      key_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitCnt_q <= bitCnt_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      toCnt_q  <= toCnt_d;
      ext_q    <= ext_d;
      rel_q    <= rel_d;
      skip_q   <= skip_d;
      key_q    <= key_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bitCnt_d = bitCnt_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    toCnt_d  = toCnt_q;
    ext_d    = ext_q;
    rel_d    = rel_q;
    skip_d   = skip_q;
    key_d    = key_q;
    err_d    = 1'b0;
    deliver  = 1'b0;

    if (state_q == IDLE || fall) toCnt_d = '0;
    else                         toCnt_d = toCnt_q + TW'(1);

    // A fall coinciding with the timeout is deliberately dropped.
    if (timeout) begin
      state_d = IDLE;
      toCnt_d = '0;
      err_d   = 1'b1;
    end else if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!dataSync_q) begin
            state_d  = DATA;
            bitCnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        DATA: begin
          shift_d  = {dataSync_q, shift_q[7:1]};
          bitCnt_d = bitCnt_q + 3'd1;
          if (bitCnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          parity_d = dataSync_q;
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (dataSync_q && (^{shift_q, parity_q})) deliver = 1'b1;
          else                                       err_d   = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    if (deliver) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 3'd1;
      end else begin
        unique case (shift_q)
          8'hE1: skip_d = 3'd7;
          8'hE0: ext_d  = 1'b1;
          8'hF0: rel_d  = 1'b1;
          8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: begin
            ext_d = 1'b0;
            rel_d = 1'b0;
          end
          default: begin
            key_d = {~key_q[10], ~rel_q, ext_q, shift_q};
            ext_d = 1'b0;
            rel_d = 1'b0;
          end
        endcase
      end
    end

    if (err_d) begin
      ext_d  = 1'b0;
      rel_d  = 1'b0;
      skip_d = '0;
    end
  end

  assign ps2_key = key_q;
  assign err     = err_q;

`ifdef PS2_RX_ERRCNT_EN
  logic [7:0] errCount_q;

  always_ff @(posedge clk) begin
    if (reset)                              errCount_q <= '0;
    else if (err_q && errCount_q != 8'hFF)  errCount_q <= errCount_q + 8'd1;
  end

  assign err_count = errCount_q;
`endif

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Scoreboard bench for ps2_key_receiver: a bench-side decoder model queues expected key events.
module tb_ps2_key_receiver;

  localparam int FILT = 8;
  localparam int TO   = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        err;

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  ps2_key_receiver #(.FILTER_LEN(FILT), .TIMEOUT_CYC(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ps2_key  (ps2_key),
    .err      (err)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Bench-side decoder model and expected-event queue
  logic [10:0] expQ[$];
  bit          mToggle = 1'b0, mExt = 1'b0, mRel = 1'b0;
  int          mSkip = 0;
  logic [10:0] mKey = '0;
  int          expErr = 0;

  function automatic void modelByte(input logic [7:0] b);
    if (mSkip != 0) mSkip--;
    else if (b == 8'hE1) mSkip = 7;
    else if (b == 8'hE0) mExt = 1'b1;
    else if (b == 8'hF0) mRel = 1'b1;
    else if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF}) begin
      mExt = 1'b0;
      mRel = 1'b0;
    end else begin
      mToggle = ~mToggle;
      mKey = {mToggle, ~mRel, mExt, b};
      expQ.push_back(mKey);
      mExt = 1'b0;
      mRel = 1'b0;
    end
  endfunction

  function automatic void modelErr();
    expErr++;
    mExt = 1'b0;
    mRel = 1'b0;
    mSkip = 0;
  endfunction

  function automatic void modelReset();
    mToggle = 1'b0;
    mExt = 1'b0;
    mRel = 1'b0;
    mSkip = 0;
    mKey = '0;
    expQ.delete();
  endfunction

  // Output monitor: pops on every toggle change, measures err pulse widths
  logic prevToggle = 1'b0;
  int   errRun = 0;
  int   errPulses = 0;

  always @(negedge clk) begin
    if (reset) begin
      prevToggle = 1'b0;
      errRun = 0;
    end else begin
      if (ps2_key[10] != prevToggle) begin
        prevToggle = ps2_key[10];
        if (expQ.size() == 0) checkOutput("unexpectedEvent", expQ.size(), 1);
        else                  checkOutput("event", ps2_key, expQ.pop_front());
      end
      if (err) errRun++;
      else if (errRun > 0) begin
        errPulses++;
        checkOutput("errWidth", errRun, 1);
        errRun = 0;
      end
    end
  end

  int lastFallCycle = 0;

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendBit(input logic b, input bit glitch);
    ps2_data = b;
    waitCycles(10);
    ps2_clk = 1'b0;
    lastFallCycle = cycle;
    waitCycles(20);
    ps2_clk = 1'b1;
    if (glitch) begin
      waitCycles(4);
      ps2_clk = 1'b0;
      waitCycles(FILT - 1);
      ps2_clk = 1'b1;
      waitCycles(9);
    end else begin
      waitCycles(20);
    end
  endtask

  task automatic sendRaw(input logic [7:0] b, input logic par, input int glitchAt);
    sendBit(1'b0, glitchAt == 0);
    for (int i = 0; i < 8; i++) sendBit(b[i], glitchAt == i + 1);
    sendBit(par, 1'b0);
    sendBit(1'b1, 1'b0);
    waitCycles(30);
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    modelByte(b);
    sendRaw(b, ~^b, -1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e0;
    int lat;
    bit seen;
    logic [7:0] e1Seq [8];
    logic [7:0] seqA [5];

    reset = 1'b1;
    waitCycles(5);
    checkOutput("resetKey", ps2_key, 11'h000);
    checkOutput("resetErr", err, 1'b0);
    reset = 1'b0;
    waitCycles(20);

    applyStimulus(8'h1C);
    checkOutput("press1C", ps2_key, 11'h61C);
    checkOutput("noErrYet", errPulses, 0);

    applyStimulus(8'hF0);
    applyStimulus(8'h1C);
    checkOutput("release1C", ps2_key, 11'h01C);

    seqA = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(seqA[i]);
      if (i == 1) checkOutput("extPress75", ps2_key, 11'h775);
    end
    checkOutput("extRelease75", ps2_key, 11'h175);

    e0 = errPulses;
    modelErr();
    sendRaw(8'h1C, 1'b1, -1);
    checkOutput("parityErr", errPulses - e0, 1);
    checkOutput("keyHeldOnErr", ps2_key, mKey);
    applyStimulus(8'h29);
    checkOutput("afterParity29", ps2_key, 11'h629);

    modelByte(8'h5A);
    sendRaw(8'h5A, ~^8'h5A, 4);
    checkOutput("glitchFrame", ps2_key, 11'h25A);
    checkOutput("glitchNoErr", errPulses, expErr);

    e0 = errPulses;
    modelErr();
    sendBit(1'b1, 1'b0);
    waitCycles(30);
    checkOutput("framingErr", errPulses - e0, 1);

    applyStimulus(8'hE0);
    applyStimulus(8'hAA);
    applyStimulus(8'h1C);
    checkOutput("specialClearsExt", ps2_key, 11'h61C);

    e1Seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 8; i++) applyStimulus(e1Seq[i]);
    applyStimulus(8'h1C);
    checkOutput("afterPause", ps2_key, 11'h21C);

    applyStimulus(8'hE0);
    sendBit(1'b0, 1'b0);
    sendBit(1'b0, 1'b0);
    sendBit(1'b0, 1'b0);
    sendBit(1'b1, 1'b0);
    seen = 1'b0;
    lat = 0;
    for (int i = 0; i < TO + 200; i++) begin
      waitCycles(1);
      if (err) begin
        seen = 1'b1;
        lat = cycle - lastFallCycle;
        break;
      end
    end
    modelErr();
    checkOutput("timeoutSeen", seen, 1'b1);
    checkOutput("timeoutLatency", (lat >= TO && lat <= TO + 20), 1'b1);
    waitCycles(30);
    applyStimulus(8'h1C);
    checkOutput("afterTimeout", ps2_key, 11'h61C);

    applyStimulus(8'hE0);
    sendBit(1'b0, 1'b0);
    sendBit(1'b1, 1'b0);
    sendBit(1'b0, 1'b0);
    reset = 1'b1;
    modelReset();
    waitCycles(4);
    checkOutput("midResetKey", ps2_key, 11'h000);
    checkOutput("midResetErr", err, 1'b0);
    reset = 1'b0;
    waitCycles(20);
    applyStimulus(8'h75);
    checkOutput("afterReset75", ps2_key, 11'h675);

    waitCycles(50);
    checkOutput("queueDrained", expQ.size(), 0);
    checkOutput("errTotal", errPulses, expErr);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
